// File: rtl/regfile_mp_if.sv
// regfile_mp_if: bundled read / writeback / allocate ports of the multi-port
// integer register file. Flat vectors, port k at [k*W +: W].
interface regfile_mp_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NREAD  = 8,
   parameter int NWRITE = 4,
   parameter int NALLOC = 4
);
   logic [NREAD*ADDR_W-1:0]  i_raddr;
   logic [NREAD*DATA_W-1:0]  o_rdata;
   logic [NREAD-1:0]         o_rready;
   logic [NWRITE-1:0]        i_we;
   logic [NWRITE*ADDR_W-1:0] i_waddr;
   logic [NWRITE*DATA_W-1:0] i_wdata;
   logic [NALLOC-1:0]        i_alloc_en;
   logic [NALLOC*ADDR_W-1:0] i_alloc_addr;

   // rename/dispatch + writeback side
   modport master (
      output i_raddr, i_we, i_waddr, i_wdata, i_alloc_en, i_alloc_addr,
      input  o_rdata, o_rready
   );

   // register file side
   modport slave (
      input  i_raddr, i_we, i_waddr, i_wdata, i_alloc_en, i_alloc_addr,
      output o_rdata, o_rready
   );
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port integer register file with per-register
// ready (scoreboard) bit. x0 reads as 0/ready and ignores writes and allocs.
// Write conflicts resolve to the highest-numbered port; alloc beats write on
// the ready flag (the allocation is the newer producer).
// Optional: define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.

// One read lane: plain mux over the flattened register image.
module regfile_mp_rd #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic [ADDR_W-1:0]                    raddr_i,
   input  logic [(1<<ADDR_W)-1:0][DATA_W-1:0]   regs_dat_i,
   input  logic [(1<<ADDR_W)-1:0]               regs_rdy_i,
   output logic [DATA_W-1:0]                    rdata_o,
   output logic                                 rready_o
);
   assign rdata_o  = regs_dat_i[raddr_i];
   assign rready_o = regs_rdy_i[raddr_i];
endmodule

module regfile_mp #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NREAD  = 8,
   parameter int NWRITE = 4,
   parameter int NALLOC = 4
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   regfile_mp_if.slave rf
);
   localparam int NREG = 1 << ADDR_W;

   // Per-port views of the flat bus vectors
   logic [NREAD-1:0][ADDR_W-1:0]  raddr;
   logic [NWRITE-1:0][ADDR_W-1:0] waddr;
   logic [NWRITE-1:0][DATA_W-1:0] wdata;
   logic [NALLOC-1:0][ADDR_W-1:0] aaddr;
   logic [NREAD-1:0][DATA_W-1:0]  rdata;
   logic [NREAD-1:0]              rready;

   // Flattened register image; entry 0 is the constant x0
   logic [NREG-1:0][DATA_W-1:0]   regs_dat;
   logic [NREG-1:0]               regs_rdy;

   assign raddr       = rf.i_raddr;
   assign waddr       = rf.i_waddr;
   assign wdata       = rf.i_wdata;
   assign aaddr       = rf.i_alloc_addr;
   assign rf.o_rdata  = rdata;
   assign rf.o_rready = rready;

   assign regs_dat[0] = '0;
   assign regs_rdy[0] = 1'b1;

   for (genvar r = 1; r < NREG; r++) begin : g_reg
      localparam logic [ADDR_W-1:0] RA = ADDR_W'(r);
      logic [DATA_W-1:0] dat_q, dat_d;
      logic              rdy_q, rdy_d;

      // Next state: ascending scan so the highest write port wins; any alloc
      // hit then clears ready regardless of writes
      always_comb begin
         dat_d = dat_q;
         rdy_d = rdy_q;
         for (int p = 0; p < NWRITE; p++) begin
            if (rf.i_we[p] && (waddr[p] == RA)) begin
               dat_d = wdata[p];
               rdy_d = 1'b1;
            end
         end
         for (int a = 0; a < NALLOC; a++) begin
            if (rf.i_alloc_en[a] && (aaddr[a] == RA)) rdy_d = 1'b0;
         end
      end

      // Register state: cleared to 0 / ready on reset
      always_ff @(posedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n) begin
            dat_q <= '0;
            rdy_q <= 1'b1;
         end else begin
            dat_q <= dat_d;
            rdy_q <= rdy_d;
         end
      end

      assign regs_dat[r] = dat_q;
      assign regs_rdy[r] = rdy_q;
   end

   for (genvar k = 0; k < NREAD; k++) begin : g_rd
      logic [DATA_W-1:0] lane_dat, lane_do;
      logic              lane_rdy, lane_ro;

      regfile_mp_rd #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd (
         .raddr_i    (raddr[k]),
         .regs_dat_i (regs_dat),
         .regs_rdy_i (regs_rdy),
         .rdata_o    (lane_dat),
         .rready_o   (lane_rdy)
      );

`ifdef REGFILE_BYPASS_EN
      logic wr_hit;

      // Forward in-flight writeback data; a same-cycle alloc makes it not-ready
      always_comb begin
         lane_do = lane_dat;
         lane_ro = lane_rdy;
         wr_hit  = 1'b0;
         if (raddr[k] != '0) begin
            for (int p = 0; p < NWRITE; p++) begin
               if (rf.i_we[p] && (waddr[p] == raddr[k])) begin
                  wr_hit  = 1'b1;
                  lane_do = wdata[p];
                  lane_ro = 1'b1;
               end
            end
            for (int a = 0; a < NALLOC; a++) begin
               if (wr_hit && rf.i_alloc_en[a] && (aaddr[a] == raddr[k])) lane_ro = 1'b0;
            end
         end
      end
`else
      // Registered state only; same-cycle writes show up next cycle
      always_comb begin
         lane_do = lane_dat;
         lane_ro = lane_rdy;
      end
`endif

      assign rdata[k]  = lane_do;
      assign rready[k] = lane_ro;
   end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed table vectors on the default 8R/4W/4A file, hand
// sequences for same-cycle read/write and reset, and a randomised run on a
// 4R/2W/2A, ADDR_W=6 instance against a small reference model.
module tb_regfile_mp;
   localparam int DW  = 32, AW  = 5, NR  = 8, NW  = 4, NA  = 4;
   localparam int AW2 = 6,  NR2 = 4, NW2 = 2, NA2 = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW),  .NREAD(NR),  .NWRITE(NW),  .NALLOC(NA))  bus ();
   regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW2), .NREAD(NR2), .NWRITE(NW2), .NALLOC(NA2)) bus2 ();

   regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NREAD(NR), .NWRITE(NW), .NALLOC(NA)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .rf(bus)
   );
   regfile_mp #(.DATA_W(DW), .ADDR_W(AW2), .NREAD(NR2), .NWRITE(NW2), .NALLOC(NA2)) dut2 (
      .i_clk(clk), .i_rst_n(rst_n), .rf(bus2)
   );

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   typedef struct packed {
      logic [3:0]       we;
      logic [3:0][4:0]  wa;
      logic [3:0][31:0] wd;
      logic [3:0]       ae;
      logic [3:0][4:0]  aa;
      logic [4:0]       ra_a;   // even read ports
      logic [4:0]       ra_b;   // odd read ports
      logic [31:0]      ed_a;
      logic [31:0]      ed_b;
      logic             er_a;
      logic             er_b;
   } vec_t;

   vec_t vt [9];

   task automatic idle();
      bus.i_we = '0; bus.i_waddr = '0; bus.i_wdata = '0;
      bus.i_alloc_en = '0; bus.i_alloc_addr = '0;
   endtask

   task automatic read_all(input logic [4:0] a);
      for (int k = 0; k < NR; k++) bus.i_raddr[k*AW +: AW] = a;
   endtask

   task automatic chk_all(input string name, input logic [31:0] ed, input logic er);
      logic [NR*DW-1:0] e_d;
      for (int k = 0; k < NR; k++) e_d[k*DW +: DW] = ed;
      chk({name, " rdata"}, bus.o_rdata, e_d);
      chk({name, " rready"}, bus.o_rready, {NR{er}});
   endtask

   initial begin
      logic [NR*DW-1:0]   e_d;
      logic [NR-1:0]      e_r;
      logic [31:0]        m_dat [64];
      logic               m_rdy [64];
      logic [NR2*DW-1:0]  e2_d;
      logic [NR2-1:0]     e2_r;
      logic [AW2-1:0]     a2;
      logic               hit;

      vt[0] = '{we:4'b0011, wa:{5'd0,5'd0,5'd0,5'd5}, wd:{32'h0,32'h0,32'h12345678,32'hDEADBEEF},
                ae:4'b0, aa:'0, ra_a:5'd3, ra_b:5'd0, ed_a:32'h0, ed_b:32'h0, er_a:1'b1, er_b:1'b1};
      vt[1] = '{we:4'b1010, wa:{5'd7,5'd0,5'd7,5'd0}, wd:{32'h33333333,32'h0,32'h11111111,32'h0},
                ae:4'b0, aa:'0, ra_a:5'd5, ra_b:5'd0, ed_a:32'hDEADBEEF, ed_b:32'h0, er_a:1'b1, er_b:1'b1};
      vt[2] = '{we:4'b0101, wa:{5'd0,5'd10,5'd0,5'd10}, wd:{32'h0,32'hBBBB0000,32'h0,32'hAAAA0000},
                ae:4'b0001, aa:{5'd0,5'd0,5'd0,5'd9}, ra_a:5'd7, ra_b:5'd5,
                ed_a:32'h33333333, ed_b:32'hDEADBEEF, er_a:1'b1, er_b:1'b1};
      vt[3] = '{we:4'b0, wa:'0, wd:'0, ae:4'b0111, aa:{5'd0,5'd0,5'd11,5'd11}, ra_a:5'd9, ra_b:5'd10,
                ed_a:32'h0, ed_b:32'hBBBB0000, er_a:1'b0, er_b:1'b1};
      vt[4] = '{we:4'b0100, wa:{5'd0,5'd9,5'd0,5'd0}, wd:{32'h0,32'hA5A5A5A5,32'h0,32'h0},
                ae:4'b0, aa:'0, ra_a:5'd11, ra_b:5'd0, ed_a:32'h0, ed_b:32'h0, er_a:1'b0, er_b:1'b1};
      vt[5] = '{we:4'b0011, wa:{5'd0,5'd0,5'd9,5'd11}, wd:{32'h0,32'h0,32'h5A5A5A5A,32'h0000CAFE},
                ae:4'b1000, aa:{5'd9,5'd0,5'd0,5'd0}, ra_a:5'd9, ra_b:5'd11,
                ed_a:32'hA5A5A5A5, ed_b:32'h0, er_a:1'b1, er_b:1'b0};
      vt[6] = '{we:4'b0, wa:'0, wd:'0, ae:4'b0, aa:'0, ra_a:5'd9, ra_b:5'd11,
                ed_a:32'h5A5A5A5A, ed_b:32'h0000CAFE, er_a:1'b0, er_b:1'b1};
      vt[7] = '{we:4'b1001, wa:{5'd31,5'd0,5'd0,5'd1}, wd:{32'hFFFFFFFF,32'h0,32'h0,32'h00000001},
                ae:4'b0, aa:'0, ra_a:5'd31, ra_b:5'd1, ed_a:32'h0, ed_b:32'h0, er_a:1'b1, er_b:1'b1};
      vt[8] = '{we:4'b0, wa:'0, wd:'0, ae:4'b0, aa:'0, ra_a:5'd31, ra_b:5'd1,
                ed_a:32'hFFFFFFFF, ed_b:32'h00000001, er_a:1'b1, er_b:1'b1};

      idle();
      read_all(5'd0);
      bus2.i_raddr = '0; bus2.i_we = '0; bus2.i_waddr = '0; bus2.i_wdata = '0;
      bus2.i_alloc_en = '0; bus2.i_alloc_addr = '0;

      // reset state
      #1;
      chk_all("reset_init", 32'h0, 1'b1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // table-driven vectors; each check precedes that vector's clock edge
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         bus.i_we = vt[i].we; bus.i_waddr = vt[i].wa; bus.i_wdata = vt[i].wd;
         bus.i_alloc_en = vt[i].ae; bus.i_alloc_addr = vt[i].aa;
         for (int k = 0; k < NR; k++) begin
            bus.i_raddr[k*AW +: AW] = (k % 2 == 0) ? vt[i].ra_a : vt[i].ra_b;
            e_d[k*DW +: DW]         = (k % 2 == 0) ? vt[i].ed_a : vt[i].ed_b;
            e_r[k]                  = (k % 2 == 0) ? vt[i].er_a : vt[i].er_b;
         end
         #1;
         chk($sformatf("vec%0d rdata", i), bus.o_rdata, e_d);
         chk($sformatf("vec%0d rready", i), bus.o_rready, e_r);
      end

      // same-cycle read/write of x12 (old 1, new 2)
      @(negedge clk);
      idle();
      bus.i_we[0] = 1'b1; bus.i_waddr[0 +: AW] = 5'd12; bus.i_wdata[0 +: DW] = 32'h1;
      read_all(5'd0);
      @(negedge clk);
      bus.i_wdata[0 +: DW] = 32'h2;
      read_all(5'd12);
      #1;
`ifdef REGFILE_BYPASS_EN
      chk_all("rw_same_x12", 32'h2, 1'b1);
`else
      chk_all("rw_same_x12", 32'h1, 1'b1);
`endif
      @(negedge clk);
      idle();
      #1;
      chk_all("rw_next_x12", 32'h2, 1'b1);

      // same-cycle write + alloc of x13 while reading it
      @(negedge clk);
      bus.i_we[3] = 1'b1; bus.i_waddr[3*AW +: AW] = 5'd13; bus.i_wdata[3*DW +: DW] = 32'h77;
      bus.i_alloc_en[0] = 1'b1; bus.i_alloc_addr[0 +: AW] = 5'd13;
      read_all(5'd13);
      #1;
`ifdef REGFILE_BYPASS_EN
      chk_all("wa_same_x13", 32'h77, 1'b0);
`else
      chk_all("wa_same_x13", 32'h0, 1'b1);
`endif
      @(negedge clk);
      idle();
      #1;
      chk_all("wa_next_x13", 32'h77, 1'b0);

      // asynchronous reset while registers hold data
      @(negedge clk);
      bus.i_raddr = {5'd1, 5'd31, 5'd13, 5'd11, 5'd10, 5'd9, 5'd7, 5'd5};
      rst_n = 1'b0;
      #1;
      chk("reset_async rdata", bus.o_rdata, '0);
      chk("reset_async rready", bus.o_rready, {NR{1'b1}});
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("reset_after rdata", bus.o_rdata, '0);
      chk("reset_after rready", bus.o_rready, {NR{1'b1}});

      // randomised run on the small instance against a reference model
      for (int r = 0; r < 64; r++) begin
         m_dat[r] = '0;
         m_rdy[r] = 1'b1;
      end
      for (int c = 0; c < 1000; c++) begin
         @(negedge clk);
         for (int p = 0; p < NW2; p++) begin
            bus2.i_we[p] = ($urandom_range(0, 2) != 0);
            bus2.i_waddr[p*AW2 +: AW2] = AW2'($urandom_range(0, ($urandom_range(0, 3) == 0) ? 63 : 7));
            bus2.i_wdata[p*DW +: DW] = $urandom;
         end
         for (int a = 0; a < NA2; a++) begin
            bus2.i_alloc_en[a] = ($urandom_range(0, 2) == 0);
            bus2.i_alloc_addr[a*AW2 +: AW2] = AW2'($urandom_range(0, ($urandom_range(0, 3) == 0) ? 63 : 7));
         end
         for (int k = 0; k < NR2; k++)
            bus2.i_raddr[k*AW2 +: AW2] = AW2'($urandom_range(0, ($urandom_range(0, 3) == 0) ? 63 : 7));
         #1;
         for (int k = 0; k < NR2; k++) begin
            a2 = bus2.i_raddr[k*AW2 +: AW2];
            e2_d[k*DW +: DW] = m_dat[a2];
            e2_r[k] = m_rdy[a2];
`ifdef REGFILE_BYPASS_EN
            hit = 1'b0;
            if (a2 != 0) begin
               for (int p = 0; p < NW2; p++) begin
                  if (bus2.i_we[p] && bus2.i_waddr[p*AW2 +: AW2] == a2) begin
                     hit = 1'b1;
                     e2_d[k*DW +: DW] = bus2.i_wdata[p*DW +: DW];
                     e2_r[k] = 1'b1;
                  end
               end
               for (int a = 0; a < NA2; a++)
                  if (hit && bus2.i_alloc_en[a] && bus2.i_alloc_addr[a*AW2 +: AW2] == a2) e2_r[k] = 1'b0;
            end
`else
            hit = 1'b0;
`endif
         end
         chk($sformatf("rand%0d rdata", c), bus2.o_rdata, e2_d);
         chk($sformatf("rand%0d rready", c), bus2.o_rready, e2_r);
         // model update for the coming edge
         for (int p = 0; p < NW2; p++) begin
            a2 = bus2.i_waddr[p*AW2 +: AW2];
            if (bus2.i_we[p] && a2 != 0) begin
               m_dat[a2] = bus2.i_wdata[p*DW +: DW];
               m_rdy[a2] = 1'b1;
            end
         end
         for (int a = 0; a < NA2; a++) begin
            a2 = bus2.i_alloc_addr[a*AW2 +: AW2];
            if (bus2.i_alloc_en[a] && a2 != 0) m_rdy[a2] = 1'b0;
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
